// File: rtl/sram_pkg.sv
// Shared types and constants for the external 64-bit SRAM device model.
package sram_pkg;

  localparam int unsigned SRAM_DATA_W   = 64;
  localparam int unsigned SRAM_LANE_W   = 32;
  localparam int unsigned DEF_ADDR_W    = 17;
  localparam int unsigned DEF_READ_LAT  = 2;
  localparam int unsigned DEF_WRITE_LAT = 1;

  typedef enum logic [1:0] {
    StIdle,
    StReadWait,
    StReadDrive,
    StWriteWait
  } sram_state_e;

endpackage

// File: rtl/sram_responder_if.sv
// SRAM pin bundle (address and active-low strobes) as driven by the memory-stage controller.
interface sram_responder_if #(
   parameter int unsigned ADDR_W = sram_pkg::DEF_ADDR_W
);

   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_WE_N;
   logic              SRAM_CE_N;
   logic              SRAM_OE_N;
   logic              SRAM_UB_N;
   logic              SRAM_LB_N;

   modport master (
      output SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
   );

   modport slave (
      input SRAM_ADDR, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N
   );

endinterface

// File: rtl/sram_array.sv
// Single-port synchronous RAM, 2^ADDR_W x 64, read-first, with 32-bit lane write enables.
module sram_array
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic                   clk,
   input  logic [ADDR_W-1:0]      addr,
   input  logic                   we,
   input  logic [1:0]             lane_we,
   input  logic [SRAM_DATA_W-1:0] wdata,
   output logic [SRAM_DATA_W-1:0] rdata
);

   localparam int unsigned Depth = 1 << ADDR_W;

   logic [SRAM_DATA_W-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we && lane_we[0]) begin
         mem[addr][SRAM_LANE_W-1:0] <= wdata[SRAM_LANE_W-1:0];
      end
      if (we && lane_we[1]) begin
         mem[addr][SRAM_DATA_W-1:SRAM_LANE_W] <= wdata[SRAM_DATA_W-1:SRAM_LANE_W];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/sram_responder.sv
// Device-side model of the external SRAM: decodes strobes, applies latencies, drives DQ,
// and keeps saturating access counters for debug.
module sram_responder
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned READ_LAT  = DEF_READ_LAT,
   parameter int unsigned WRITE_LAT = DEF_WRITE_LAT
) (
   input  logic                   clk,
   input  logic                   rst,
   sram_responder_if.slave        bus,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic                   busy,
   output logic [15:0]            rd_count,
   output logic [15:0]            wr_count
);

   localparam logic [3:0] ReadLatM1  = 4'(READ_LAT - 1);
   localparam logic [3:0] WriteLatM1 = 4'(WRITE_LAT - 1);

   sram_state_e            state_q, state_d;
   logic [3:0]             lat_q, lat_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic [SRAM_DATA_W-1:0] dout_q, dout_d;
   logic [1:0]             lane_q, lane_d;
   logic [15:0]            rd_count_q, wr_count_q;
   logic                   busy_q;
   logic                   rd_hit, wr_hit;
   logic                   req_wr, req_rd, strobe_off, addr_chg, dq_oe;
   logic [SRAM_DATA_W-1:0] ram_rdata;

   assign req_wr     = !bus.SRAM_CE_N && !bus.SRAM_WE_N;
   assign req_rd     = !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
   assign strobe_off = bus.SRAM_CE_N || bus.SRAM_OE_N;
   assign addr_chg   = bus.SRAM_ADDR != addr_q;

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      lane_d  = lane_q;
      dout_d  = dout_q;
      rd_hit  = 1'b0;
      wr_hit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_wr) begin
               addr_d  = bus.SRAM_ADDR;
               wdata_d = SRAM_DQ;
               lane_d  = ~{bus.SRAM_UB_N, bus.SRAM_LB_N};
               lat_d   = WriteLatM1;
               state_d = StWriteWait;
            end else if (req_rd) begin
               addr_d  = bus.SRAM_ADDR;
               lat_d   = ReadLatM1;
               state_d = StReadWait;
            end
         end
         StReadWait: begin
            if (strobe_off) begin
               state_d = StIdle;
            end else if (addr_chg) begin
               addr_d = bus.SRAM_ADDR;
               lat_d  = ReadLatM1;
            end else if (lat_q == 4'd0) begin
               dout_d  = ram_rdata;
               rd_hit  = 1'b1;
               state_d = StReadDrive;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         StReadDrive: begin
            if (strobe_off) begin
               state_d = StIdle;
            end else if (addr_chg) begin
               addr_d  = bus.SRAM_ADDR;
               lat_d   = ReadLatM1;
               state_d = StReadWait;
            end
         end
         StWriteWait: begin
            if (lat_q == 4'd0) begin
               wr_hit  = 1'b1;
               state_d = StIdle;
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         lat_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         lane_q     <= '0;
         dout_q     <= '0;
         rd_count_q <= '0;
         wr_count_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         lane_q  <= lane_d;
         dout_q  <= dout_d;
         busy_q  <= state_d != StIdle;
         if (rd_hit && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
         if (wr_hit && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end
   end

   // RAM is addressed with the next-state address so its registered read is already
   // valid on the edge where the latency counter reaches zero.
   sram_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .addr    (addr_d),
      .we      (wr_hit && !rst),
      .lane_we (lane_q),
      .wdata   (wdata_q),
      .rdata   (ram_rdata)
   );

   assign dq_oe    = (state_q == StReadDrive) && !strobe_off;
   assign SRAM_DQ  = dq_oe ? dout_q : {SRAM_DATA_W{1'bz}};
   assign busy     = busy_q;
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: timing-rule model plus per-cycle compare and literal pins.
module tb_sram_responder;

   localparam int unsigned AW = 17;
   localparam int unsigned RL = 2;
   localparam int unsigned WL = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_responder_if #(.ADDR_W(AW)) bus ();

   tri1  [63:0] dq;
   logic        tb_drv = 1'b0;
   logic [63:0] tb_dq  = '0;
   assign dq = tb_drv ? tb_dq : 64'bz;

   logic        busy;
   logic [15:0] rd_count, wr_count;

   sram_responder #(
      .ADDR_W    (AW),
      .READ_LAT  (RL),
      .WRITE_LAT (WL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .SRAM_DQ  (dq),
      .busy     (busy),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   // Model state: memory image, counters, and what the pins must show this cycle.
   logic [63:0] mem_m [logic [AW-1:0]];
   logic [15:0] mdl_rd = '0, mdl_wr = '0;
   logic        exp_busy = 1'b0, exp_drv = 1'b0;
   logic [63:0] exp_dq = '0;
   logic        chk_en = 1'b0;
   int          checks = 0, errors = 0;
   logic [63:0] seen, seen2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("rd_count", 64'(rd_count), 64'(mdl_rd));
         chk("wr_count", 64'(wr_count), 64'(mdl_wr));
         if (!tb_drv) chk("dq", dq, exp_drv ? exp_dq : 64'hFFFF_FFFF_FFFF_FFFF);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.SRAM_CE_N = 1'b1;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b1;
      bus.SRAM_UB_N = 1'b0;
      bus.SRAM_LB_N = 1'b0;
      tb_drv        = 1'b0;
   endtask

   // Drive the write strobe for one sample; commit lands WL edges after acceptance.
   task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic ub_n,
                           input logic lb_n, input logic oe_n);
      logic [63:0] cur;
      bus.SRAM_ADDR = a;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_WE_N = 1'b0;
      bus.SRAM_OE_N = oe_n;
      bus.SRAM_UB_N = ub_n;
      bus.SRAM_LB_N = lb_n;
      tb_dq  = d;
      tb_drv = 1'b1;
      step();
      bus_idle();
      exp_busy = 1'b1;
      repeat (WL - 1) step();
      step();
      exp_busy = 1'b0;
      mdl_wr   = sat_inc(mdl_wr);
      cur = mem_m.exists(a) ? mem_m[a] : 64'd0;
      if (!ub_n) cur[63:32] = d[63:32];
      if (!lb_n) cur[31:0]  = d[31:0];
      mem_m[a] = cur;
   endtask

   task automatic read_start(input logic [AW-1:0] a);
      bus.SRAM_ADDR = a;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b0;
   endtask

   // Wait out the read latency from an accept/reload edge, then expect data on DQ.
   task automatic read_data(input logic [AW-1:0] a, output logic [63:0] got);
      step();
      exp_busy = 1'b1;
      exp_drv  = 1'b0;
      repeat (RL - 1) step();
      step();
      mdl_rd  = sat_inc(mdl_rd);
      exp_drv = 1'b1;
      exp_dq  = mem_m[a];
      got     = dq;
   endtask

   task automatic read_end();
      bus_idle();
      exp_drv = 1'b0;
      step();
      exp_busy = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold, output logic [63:0] got);
      read_start(a);
      read_data(a, got);
      repeat (hold) step();
      read_end();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst      = 1'b0;
      mdl_rd   = '0;
      mdl_wr   = '0;
      exp_busy = 1'b0;
      exp_drv  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus_idle();
      bus.SRAM_ADDR = '0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_counts", {32'd0, rd_count, wr_count}, 64'd0);

      // Full-width write and readback.
      do_write(17'h00010, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0, 1'b1);
      do_read(17'h00010, 1, seen);
      chk("first_read", seen, 64'hDEADBEEF_CAFEF00D);
      chk("first_counts", {32'd0, rd_count, wr_count}, {32'd0, 16'd1, 16'd1});

      // Upper-lane-only write, then a write with both lanes disabled.
      do_write(17'h1FFFF, 64'h11111111_22222222, 1'b0, 1'b0, 1'b1);
      do_write(17'h1FFFF, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 1'b1, 1'b1);
      do_read(17'h1FFFF, 0, seen);
      chk("upper_lane", seen, 64'hAAAAAAAA_22222222);
      do_write(17'h1FFFF, 64'h55555555_55555555, 1'b1, 1'b1, 1'b1);
      do_read(17'h1FFFF, 2, seen);
      chk("no_lane", seen, 64'hAAAAAAAA_22222222);
      chk("no_lane_wr_count", 64'(wr_count), 64'd4);

      // Pipelined re-read through an address change while driving.
      read_start(17'h00010);
      read_data(17'h00010, seen);
      bus.SRAM_ADDR = 17'h1FFFF;
      read_data(17'h1FFFF, seen2);
      read_end();
      chk("pipe_a", seen, 64'hDEADBEEF_CAFEF00D);
      chk("pipe_b", seen2, 64'hAAAAAAAA_22222222);
      chk("pipe_rd_count", 64'(rd_count), 64'd5);

      // Read aborted by OE_N rising during the latency wait.
      read_start(17'h00020);
      step();
      exp_busy = 1'b1;
      bus.SRAM_OE_N = 1'b1;
      step();
      exp_busy = 1'b0;
      bus_idle();
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_rd_count", 64'(rd_count), 64'd5);

      // Reset while a write is pending drops the write.
      do_write(17'h00030, 64'd0, 1'b0, 1'b0, 1'b1);
      bus.SRAM_ADDR = 17'h00030;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_WE_N = 1'b0;
      tb_dq  = 64'h01234567_89ABCDEF;
      tb_drv = 1'b1;
      step();
      bus_idle();
      exp_busy = 1'b1;
      pulse_rst();
      do_read(17'h00030, 0, seen);
      chk("dropped_write", seen, 64'd0);
      chk("dropped_wr_count", 64'(wr_count), 64'd0);

      // Committed data survives reset.
      do_write(17'h00040, 64'hFEEDFACE_0BADF00D, 1'b0, 1'b0, 1'b1);
      pulse_rst();
      do_read(17'h00040, 0, seen);
      chk("survive_reset", seen, 64'hFEEDFACE_0BADF00D);

      // WE_N and OE_N low together: a write, DQ never driven by the device.
      do_write(17'h00050, 64'h12345678_9ABCDEF0, 1'b0, 1'b0, 1'b0);
      chk("we_oe_counts", {32'd0, rd_count, wr_count}, {32'd0, 16'd1, 16'd1});
      do_read(17'h00050, 0, seen);
      chk("we_oe_data", seen, 64'h12345678_9ABCDEF0);

      // Read counter saturation.
      force dut.rd_count_q = 16'hFFFE;
      mdl_rd = 16'hFFFE;
      #1;
      release dut.rd_count_q;
      step();
      for (int i = 0; i < 3; i++) do_read(17'h00050, 0, seen);
      chk("rd_saturate", 64'(rd_count), 64'hFFFF);

      step();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
